// File: rtl/vtiming_ctrl_if.sv
// Vertical timing bus between the vertical counter / consumers and vtiming_ctrl.
//   HRESET, VRESET : line-rate / frame-rate reset levels (rising edge = boundary)
//   V              : 9-bit vertical count
//   VBLANK, VSYNC  : registered vertical windows
//   FRAME_TICK     : one-cycle pulse per frame
//   FRAME_CNT      : frames since reset, wraps at 256
//   LOCKED, VLOST  : raster stable / sticky watchdog loss
// master drives the counter inputs, slave (the sequencer) drives the status outputs.
interface vtiming_ctrl_if;
  logic       HRESET;
  logic       VRESET;
  logic [8:0] V;
  logic       VBLANK;
  logic       VSYNC;
  logic       FRAME_TICK;
  logic [7:0] FRAME_CNT;
  logic       LOCKED;
  logic       VLOST;

  modport master (
    output HRESET, VRESET, V,
    input  VBLANK, VSYNC, FRAME_TICK, FRAME_CNT, LOCKED, VLOST
  );

  modport slave (
    input  HRESET, VRESET, V,
    output VBLANK, VSYNC, FRAME_TICK, FRAME_CNT, LOCKED, VLOST
  );
endinterface

// File: rtl/vtiming_ctrl.sv
// Vertical timing sequencer.
// Detects line (HRESET) and frame (VRESET) rising edges, builds VBLANK/VSYNC windows
// from the V count sampled on line ticks, emits a frame strobe and frame counter, and
// runs a lock/watchdog FSM so downstream logic only trusts a stable raster.
// Ports:
//   CLK_DRV : system clock, rising edge
//   RESET   : synchronous active-high reset
//   bus     : vtiming_ctrl_if.slave (HRESET, VRESET, V in; windows and status out)
module vtiming_ctrl #(
  parameter int unsigned VBLANK_START = 248,
  parameter int unsigned VBLANK_END   = 16,
  parameter int unsigned VSYNC_START  = 252,
  parameter int unsigned VSYNC_END    = 256,
  parameter int unsigned FRAME_LINES  = 262,
  parameter int unsigned WDOG_LINES   = 300
) (
  input  logic          CLK_DRV,
  input  logic          RESET,
  vtiming_ctrl_if.slave bus
);

  localparam logic [8:0] VblankSet = 9'(VBLANK_START);
  localparam logic [8:0] VblankClr = 9'(VBLANK_END);
  localparam logic [8:0] VsyncSet  = 9'(VSYNC_START);
  localparam logic [8:0] VsyncClr  = 9'(VSYNC_END);
  localparam logic [9:0] FrameLen  = 10'(FRAME_LINES);
  localparam logic [8:0] WdogCnt   = 9'(WDOG_LINES);

  typedef enum logic [1:0] {StUnlocked, StAcquire, StLocked} state_e;

  state_e     state_q, state_d;
  logic       hres_q, vres_q;
  logic [8:0] line_cnt_q;
  logic       vblank_q, vsync_q, frame_tick_q, locked_q, vlost_q;
  logic [7:0] frame_cnt_q;

  logic       line_tick, frame_edge, wdog_hit;
  logic [8:0] line_inc;
  logic [9:0] meas;

  assign line_tick  = bus.HRESET & ~hres_q;
  assign frame_edge = bus.VRESET & ~vres_q;
  assign line_inc   = (line_cnt_q == 9'h1FF) ? line_cnt_q : line_cnt_q + 9'd1;
  // A tick coincident with the frame edge still belongs to the frame being closed.
  assign meas       = {1'b0, line_cnt_q} + {9'd0, line_tick};
  // Fires once, on the tick that brings the count up to the limit.
  assign wdog_hit   = line_tick & ~frame_edge & (line_cnt_q != line_inc) &
                      (line_inc == WdogCnt);

  always_comb begin
    state_d = state_q;
    if (frame_edge) begin
      unique case (state_q)
        StUnlocked: state_d = StAcquire;
        StAcquire,
        StLocked:   state_d = (meas == FrameLen) ? StLocked : StAcquire;
        default:    state_d = StUnlocked;
      endcase
    end else if (wdog_hit) begin
      state_d = StUnlocked;
    end
  end

  always_ff @(posedge CLK_DRV) begin
    if (RESET) begin
      // Edge registers start high so a level held through reset makes no tick.
      hres_q       <= 1'b1;
      vres_q       <= 1'b1;
      line_cnt_q   <= 9'd0;
      state_q      <= StUnlocked;
      vblank_q     <= 1'b1;
      vsync_q      <= 1'b0;
      frame_tick_q <= 1'b0;
      frame_cnt_q  <= 8'd0;
      locked_q     <= 1'b0;
      vlost_q      <= 1'b0;
    end else begin
      hres_q       <= bus.HRESET;
      vres_q       <= bus.VRESET;
      frame_tick_q <= frame_edge;
      state_q      <= state_d;
      locked_q     <= (state_d == StLocked);
      vlost_q      <= vlost_q | wdog_hit;

      if (frame_edge) begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
        line_cnt_q  <= 9'd0;
      end else if (line_tick) begin
        line_cnt_q  <= line_inc;
      end

      // Set has priority when set and clear compare points coincide.
      if (line_tick) begin
        if (bus.V == VblankSet) begin
          vblank_q <= 1'b1;
        end else if (bus.V == VblankClr) begin
          vblank_q <= 1'b0;
        end
        if (bus.V == VsyncSet) begin
          vsync_q <= 1'b1;
        end else if (bus.V == VsyncClr) begin
          vsync_q <= 1'b0;
        end
      end
    end
  end

  assign bus.VBLANK     = vblank_q;
  assign bus.VSYNC      = vsync_q;
  assign bus.FRAME_TICK = frame_tick_q;
  assign bus.FRAME_CNT  = frame_cnt_q;
  assign bus.LOCKED     = locked_q;
  assign bus.VLOST      = vlost_q;

endmodule
